neuron_simd: RTL and testbench

//   Parametrised multi-lane successor of the single-MAC neuron. Accepts LANES inputs per beat, does LANES

---
 rtl/neuron_simd_if.sv | 46 ++++
 rtl/neuron_simd.sv | 266 ++++++++++++++++++++++++++
 tb/tb_neuron_simd.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_simd_if.sv
// neuron_simd_if: bundles the configuration bus, the input beat stream and
// the result stream of one neuron_simd instance.
//   master modport: the side that drives config writes, input beats and out_ready
//                   (layer control logic or a testbench)
//   slave modport : the neuron itself
// Signals:
//   cfg_layer/cfg_neuron    target ids for weight/bias writes
//   weight_valid/value      weight write strobe, weight in [DATA_W-1:0]
//   bias_valid/value        bias write strobe, bias in [DATA_W-1:0]
//   act_mode                0/3 linear, 1 ReLU, 2 hard-tanh clip
//   in_valid/ready/data     LANES elements per beat, lane i at [i*DATA_W +: DATA_W]
//   out_valid/ready/data    activated result, held until accepted
//   out_ovf                 sticky saturation flag of the inference being reported
interface neuron_simd_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16
);
  logic [31:0]             cfg_layer;
  logic [31:0]             cfg_neuron;
  logic                    weight_valid;
  logic [31:0]             weight_value;
  logic                    bias_valid;
  logic [31:0]             bias_value;
  logic [1:0]              act_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ovf;

  modport master (
    output cfg_layer, cfg_neuron, weight_valid, weight_value,
    output bias_valid, bias_value, act_mode,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  cfg_layer, cfg_neuron, weight_valid, weight_value,
    input  bias_valid, bias_value, act_mode,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/neuron_simd.sv
// neuron_simd: multi-lane fixed-point neuron. Each accepted beat carries
// LANES inputs which are multiplied against per-lane weight banks and summed
// into a saturating accumulator. After the last beat the bias is added, the
// activation is applied and the result is offered on the output handshake.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (weights and bias are kept)
//   bus  neuron_simd_if.slave: config writes, input beats, result stream
module neuron_simd #(
  parameter int LAYER_NO   = 0,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 784,
  parameter int LANES      = 4,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  neuron_simd_if.slave bus
);
  localparam int BEATS      = (NUM_WEIGHT + LANES - 1) / LANES;
  localparam int ACC_W      = 2 * DATA_W + $clog2(NUM_WEIGHT) + 1;
  localparam int PROD_W     = 2 * DATA_W;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WCNT_W     = $clog2(NUM_WEIGHT + 1);
  // number of real elements in the final beat; lanes at or above it are padding
  localparam int LAST_LANES = NUM_WEIGHT - (BEATS - 1) * LANES;

  localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ACT_ONE  = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] ACT_MONE = -ACT_ONE;

  typedef enum logic [1:0] {ST_ACCUM, ST_BIAS, ST_ACT, ST_OUT} state_t;

  state_t state_reg, state_next;

  logic id_match, wr_en, bias_en, accept, last_beat;
  logic in_ready_int, out_valid_int;

  logic [LANE_W-1:0] wr_lane_reg;
  logic [BEAT_W-1:0] wr_row_reg;
  logic [WCNT_W-1:0] wr_cnt_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic              done_reg;   // all beats of this inference accepted

  logic s1_valid_reg, s1_last_reg, s2_valid_reg, s2_last_reg;

  logic signed [DATA_W-1:0] bias_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic                     ovf_reg;
  logic [DATA_W-1:0]        out_data_reg;

  logic signed [PROD_W-1:0] prod [LANES];

  logic unused_bits;
  assign unused_bits = ^{bus.weight_value[31:DATA_W], bus.bias_value[31:DATA_W]};

  // ---------------------------------------------------------------- config
  assign id_match  = (bus.cfg_layer == 32'(LAYER_NO)) && (bus.cfg_neuron == 32'(NEURON_NO));
  assign wr_en     = id_match && bus.weight_valid;
  assign bias_en   = id_match && bus.bias_valid;
  assign accept    = bus.in_valid && in_ready_int;
  assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (bias_en) begin
      bias_reg <= bus.bias_value[DATA_W-1:0];
    end
  end

  // weight k lands in bank k%LANES, row k/LANES; tracked as lane/row counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_lane_reg <= '0;
      wr_row_reg  <= '0;
      wr_cnt_reg  <= '0;
    end else if (wr_en) begin
      if (wr_cnt_reg == WCNT_W'(NUM_WEIGHT - 1)) begin
        wr_lane_reg <= '0;
        wr_row_reg  <= '0;
        wr_cnt_reg  <= '0;
      end else begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
        if (wr_lane_reg == LANE_W'(LANES - 1)) begin
          wr_lane_reg <= '0;
          wr_row_reg  <= wr_row_reg + 1'b1;
        end else begin
          wr_lane_reg <= wr_lane_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- lanes
  // S1: input register plus registered bank read at the current beat row.
  // S2: signed product; padding lanes of the final beat contribute zero.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam bit LANE_PAD = (gi >= LAST_LANES);

      logic [DATA_W-1:0]        w_mem [BEATS];
      logic signed [DATA_W-1:0] w_rd_reg;
      logic signed [DATA_W-1:0] x_reg;
      logic signed [PROD_W-1:0] prod_full;
      logic signed [PROD_W-1:0] prod_reg;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_lane_reg == LANE_W'(gi))) begin
          w_mem[wr_row_reg] <= bus.weight_value[DATA_W-1:0];
        end
        w_rd_reg <= w_mem[beat_reg];
      end

      assign prod_full = x_reg * w_rd_reg;

      always_ff @(posedge clk) begin
        if (accept) begin
          x_reg <= bus.in_data[gi*DATA_W +: DATA_W];
        end
        prod_reg <= (LANE_PAD && s1_last_reg) ? '0 : prod_full;
      end

      assign prod[gi] = prod_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- S3 / bias / act datapath
  logic signed [ACC_W-1:0] lane_sum;
  logic        [ACC_W:0]   mac_wide;
  logic signed [ACC_W-1:0] mac_sat;
  logic                    mac_ovf;
  logic        [ACC_W-1:0] bias_ext;
  logic        [ACC_W:0]   bias_wide;
  logic signed [ACC_W-1:0] bias_sat;
  logic                    bias_ovf;
  logic signed [ACC_W-1:0] t_full;
  logic [ACC_W-DATA_W:0]   t_upper;
  logic                    t_ovf;
  logic signed [DATA_W-1:0] t_sat;
  logic signed [DATA_W-1:0] act_val;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end
    // one guard bit: overflow shows as the guard differing from the sign
    mac_wide = {acc_reg[ACC_W-1], acc_reg} + {lane_sum[ACC_W-1], lane_sum};
    mac_ovf  = mac_wide[ACC_W] ^ mac_wide[ACC_W-1];
    mac_sat  = mac_ovf ? (mac_wide[ACC_W] ? ACC_MIN : ACC_MAX) : mac_wide[ACC_W-1:0];

    // bias shares the data Q format, so align it to the product scale
    bias_ext  = {{(ACC_W-DATA_W){bias_reg[DATA_W-1]}}, bias_reg} << FRAC_W;
    bias_wide = {acc_reg[ACC_W-1], acc_reg} + {bias_ext[ACC_W-1], bias_ext};
    bias_ovf  = bias_wide[ACC_W] ^ bias_wide[ACC_W-1];
    bias_sat  = bias_ovf ? (bias_wide[ACC_W] ? ACC_MIN : ACC_MAX) : bias_wide[ACC_W-1:0];

    t_full  = acc_reg >>> FRAC_W;
    t_upper = t_full[ACC_W-1:DATA_W-1];
    t_ovf   = !((&t_upper) || !(|t_upper));
    t_sat   = t_ovf ? (t_full[ACC_W-1] ? DATA_MIN : DATA_MAX) : t_full[DATA_W-1:0];

    case (bus.act_mode)
      2'd1: act_val = t_sat[DATA_W-1] ? '0 : t_sat;
      2'd2: begin
        if (t_sat > ACT_ONE) begin
          act_val = ACT_ONE;
        end else if (t_sat < ACT_MONE) begin
          act_val = ACT_MONE;
        end else begin
          act_val = t_sat;
        end
      end
      default: act_val = t_sat;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACCUM: if (s2_valid_reg && s2_last_reg) state_next = ST_BIAS;
      ST_BIAS:  state_next = ST_ACT;
      ST_ACT:   state_next = ST_OUT;
      ST_OUT:   if (bus.out_ready) state_next = ST_ACCUM;
      default:  state_next = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready_int  = (state_reg == ST_ACCUM) && !done_reg && !wr_en;
    out_valid_int = (state_reg == ST_OUT);
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ovf   = ovf_reg;

  // ---------------------------------------------------------------- sequential datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg     <= '0;
      done_reg     <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
      out_data_reg <= '0;
    end else begin
      s1_valid_reg <= accept;
      s1_last_reg  <= accept && last_beat;
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;

      if (accept) begin
        if (last_beat) begin
          beat_reg <= '0;
          done_reg <= 1'b1;
        end else begin
          beat_reg <= beat_reg + 1'b1;
        end
      end

      case (state_reg)
        ST_ACCUM: begin
          if (s2_valid_reg) begin
            acc_reg <= mac_sat;
            if (mac_ovf) ovf_reg <= 1'b1;
          end
        end
        ST_BIAS: begin
          acc_reg <= bias_sat;
          if (bias_ovf) ovf_reg <= 1'b1;
        end
        ST_ACT: begin
          out_data_reg <= act_val;
          if (t_ovf) ovf_reg <= 1'b1;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            acc_reg  <= '0;
            ovf_reg  <= 1'b0;
            done_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_simd.sv
// tb_neuron_simd: drives neuron_simd with directed and randomized inferences
// and checks every valid output cycle against a plain-arithmetic model.
module tb_neuron_simd;
  localparam int NW        = 6;
  localparam int LN        = 4;
  localparam int DW        = 16;
  localparam int FW        = 12;
  localparam int BEATS     = (NW + LN - 1) / LN;
  localparam int ACC_W     = 2 * DW + $clog2(NW) + 1;
  localparam int LAYER_ID  = 3;
  localparam int NEURON_ID = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_simd_if #(.LANES(LN), .DATA_W(DW)) bus ();

  neuron_simd #(
    .LAYER_NO(LAYER_ID), .NEURON_NO(NEURON_ID), .NUM_WEIGHT(NW),
    .LANES(LN), .DATA_W(DW), .FRAC_W(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  shortint w_model [NW];
  shortint bias_model;
  int      wr_ptr;
  shortint x_cur [NW];

  logic [DW-1:0] exp_d_q [$];
  bit            exp_o_q [$];
  time           rise_time;
  time           last_acc_time;
  bit            prev_valid;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference: exact sum of products, saturate, add bias, floor-shift, clamp.
  function automatic void model(input logic [1:0] mode, output logic [DW-1:0] d, output bit ovf);
    longint amax = (longint'(1) <<< (ACC_W - 1)) - 1;
    longint amin = -(longint'(1) <<< (ACC_W - 1));
    longint one  = longint'(1) <<< FW;
    longint acc  = 0;
    longint t;
    ovf = 1'b0;
    for (int k = 0; k < NW; k++) acc += longint'(x_cur[k]) * longint'(w_model[k]);
    if (acc > amax) begin acc = amax; ovf = 1'b1; end
    if (acc < amin) begin acc = amin; ovf = 1'b1; end
    acc += longint'(bias_model) * one;
    if (acc > amax) begin acc = amax; ovf = 1'b1; end
    if (acc < amin) begin acc = amin; ovf = 1'b1; end
    t = acc >>> FW;
    if (t > 32767)  begin t = 32767;  ovf = 1'b1; end
    if (t < -32768) begin t = -32768; ovf = 1'b1; end
    if (mode == 2'd1 && t < 0) t = 0;
    if (mode == 2'd2) begin
      if (t > one)  t = one;
      if (t < -one) t = -one;
    end
    d = DW'(t);
  endfunction

  function automatic logic [DW-1:0] rv(input bit big);
    logic [DW-1:0] v;
    if (big) v = 16'($urandom);
    else     v = 16'($urandom_range(0, 16'h3000)) - 16'h1800;
    return v;
  endfunction

  task automatic cfg_write(input bit is_bias, input logic [DW-1:0] v, input bit match);
    bus.cfg_layer    = LAYER_ID;
    bus.cfg_neuron   = match ? NEURON_ID : NEURON_ID + 1;
    bus.weight_value = {16'($urandom), v};
    bus.bias_value   = {16'($urandom), v};
    if (is_bias) bus.bias_valid = 1'b1;
    else         bus.weight_valid = 1'b1;
    @(posedge clk); #1;
    bus.weight_valid = 1'b0;
    bus.bias_valid   = 1'b0;
    if (match) begin
      if (is_bias) bias_model = shortint'(v);
      else begin
        w_model[wr_ptr] = shortint'(v);
        wr_ptr = (wr_ptr == NW - 1) ? 0 : wr_ptr + 1;
      end
    end
  endtask

  task automatic load_all(input logic [DW-1:0] v);
    for (int k = 0; k < NW; k++) cfg_write(1'b0, v, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
  endtask

  // One inference: push the expectation, feed the beats, then let the
  // monitor consume the result under the requested back-pressure.
  task automatic run_inf(input logic [1:0] mode, input bit gaps, input bit bp, input int hold);
    logic [DW-1:0]    ed;
    bit               eo;
    logic [LN*DW-1:0] pk;
    bit               ok;
    bit               got;
    int               h;
    model(mode, ed, eo);
    exp_d_q.push_back(ed);
    exp_o_q.push_back(eo);
    bus.act_mode  = mode;
    h             = hold;
    bus.out_ready = (h > 0) ? 1'b0 : 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int l = 0; l < LN; l++) begin
        if (b * LN + l < NW) pk[l*DW +: DW] = DW'(x_cur[b*LN+l]);
        else                 pk[l*DW +: DW] = gaps ? 16'($urandom) : 16'h7FFF;
      end
      bus.in_data  = pk;
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        if (ok) begin
          got = 1'b1;
          last_acc_time = $time;
        end
      end
      #1 bus.in_valid = 1'b0;
      if (!got) fail_now("beat_accept");
    end
    for (int c = 0; c < 300 && exp_d_q.size() != 0; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid && h > 0) h--;
      bus.out_ready = (h > 0) ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    if (exp_d_q.size() != 0) begin
      fail_now("result_wait");
      exp_d_q.delete();
      exp_o_q.delete();
    end else begin
      check("latency_cycles", 32'((rise_time - last_acc_time) / 10), 32'd4);
    end
    bus.out_ready = 1'b1;
  endtask

  // Compare process: every cycle with out_valid high is checked.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (!prev_valid) rise_time = $time;
        if (exp_d_q.size() == 0) begin
          fail_now("spurious_out_valid");
        end else begin
          check("out_data", 32'(bus.out_data), 32'(exp_d_q[0]));
          check("out_ovf",  32'(bus.out_ovf),  32'(exp_o_q[0]));
          check("in_ready_during_out", 32'(bus.in_ready), 32'd0);
          if (bus.out_ready) begin
            $display("result data=%h ovf=%0d", bus.out_data, bus.out_ovf);
            void'(exp_d_q.pop_front());
            void'(exp_o_q.pop_front());
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pd;
    bit            po;
    bit            big;
    logic [LN*DW-1:0] pk;

    rst = 1'b1;
    bus.cfg_layer = '0; bus.cfg_neuron = '0;
    bus.weight_valid = 1'b0; bus.weight_value = '0;
    bus.bias_valid = 1'b0; bus.bias_value = '0;
    bus.act_mode = 2'd0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b1;
    wr_ptr = 0;
    bias_model = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");

    // basic: 1.0 weights, 0.5 inputs, a foreign-id write in between is ignored
    cfg_write(1'b0, 16'h1000, 1'b1);
    cfg_write(1'b0, 16'h7FFF, 1'b0);
    for (int k = 1; k < NW; k++) cfg_write(1'b0, 16'h1000, 1'b1);
    cfg_write(1'b1, 16'h0000, 1'b1);
    for (int k = 0; k < NW; k++) x_cur[k] = 16'sh0800;
    model(2'd0, pd, po);
    check("pin_basic", 32'(pd), 32'h3000);
    run_inf(2'd0, 1'b0, 1'b0, 0);

    // ReLU on a negative sum, hard-tanh on a large positive sum
    for (int k = 0; k < NW; k++) x_cur[k] = -16'sh0400;
    model(2'd1, pd, po);
    check("pin_relu", 32'(pd), 32'h0000);
    run_inf(2'd1, 1'b0, 1'b0, 0);
    for (int k = 0; k < NW; k++) x_cur[k] = 16'sh1000;
    model(2'd2, pd, po);
    check("pin_clip", 32'(pd), 32'h1000);
    run_inf(2'd2, 1'b0, 1'b0, 0);

    // distinct weights/inputs, padding lanes carry 0x7FFF
    cfg_write(1'b0, 16'h1000, 1'b1); cfg_write(1'b0, 16'h0800, 1'b1);
    cfg_write(1'b0, 16'hF000, 1'b1); cfg_write(1'b0, 16'h2000, 1'b1);
    cfg_write(1'b0, 16'h0400, 1'b1); cfg_write(1'b0, 16'hF800, 1'b1);
    cfg_write(1'b1, 16'h0400, 1'b1);
    x_cur[0] = 16'sh1000; x_cur[1] = 16'sh1000; x_cur[2] = 16'sh0800;
    x_cur[3] = 16'sh0800; x_cur[4] = 16'sh2000; x_cur[5] = -16'sh1000;
    model(2'd0, pd, po);
    check("pin_mask", 32'(pd), 32'h3400);
    run_inf(2'd0, 1'b0, 1'b0, 0);

    // saturation, then a clean inference must report no overflow
    load_all(16'h7FFF);
    cfg_write(1'b1, 16'h0000, 1'b1);
    for (int k = 0; k < NW; k++) x_cur[k] = 16'sh7FFF;
    model(2'd0, pd, po);
    check("pin_sat_data", 32'(pd), 32'h7FFF);
    check("pin_sat_ovf", 32'(po), 32'd1);
    run_inf(2'd0, 1'b0, 1'b0, 0);
    load_all(16'h1000);
    for (int k = 0; k < NW; k++) x_cur[k] = 16'sh0800;
    run_inf(2'd0, 1'b0, 1'b0, 0);

    // out_ready held low for 10 valid cycles
    run_inf(2'd3, 1'b0, 1'b0, 10);

    // matched write steals in_ready for exactly that cycle; foreign write does not
    @(posedge clk); #1;
    bus.cfg_layer = LAYER_ID; bus.cfg_neuron = NEURON_ID;
    bus.weight_value = 32'h0000_1000; bus.weight_valid = 1'b1;
    @(negedge clk);
    check("in_ready_wr_cycle", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.weight_valid = 1'b0;
    w_model[wr_ptr] = 16'sh1000;
    wr_ptr = (wr_ptr == NW - 1) ? 0 : wr_ptr + 1;
    @(negedge clk);
    check("in_ready_after_wr", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.cfg_layer = LAYER_ID + 1; bus.weight_valid = 1'b1;
    @(negedge clk);
    check("in_ready_foreign_wr", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.weight_valid = 1'b0;

    // reset after the first beat, then a fresh inference
    for (int l = 0; l < LN; l++) pk[l*DW +: DW] = 16'h7FFF;
    bus.in_data = pk; bus.in_valid = 1'b1;
    @(negedge clk);
    check("abort_beat_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_ptr = 0;
    check_idle_outputs("midreset");
    load_all(16'h1000);
    for (int k = 0; k < NW; k++) x_cur[k] = 16'sh0800;
    model(2'd0, pd, po);
    check("pin_after_reset", 32'(pd), 32'h3000);
    run_inf(2'd0, 1'b0, 1'b0, 0);

    // randomized inferences
    for (int it = 0; it < 40; it++) begin
      big = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < NW; k++) cfg_write(1'b0, rv(big), 1'b1);
      end
      if ($urandom_range(0, 3) == 0) cfg_write(1'b0, rv(1'b1), 1'b0);
      if ($urandom_range(0, 1) == 1) cfg_write(1'b1, rv(big), 1'b1);
      for (int k = 0; k < NW; k++) x_cur[k] = shortint'(rv(big));
      run_inf(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
